pwm_ramp_ctrl: RTL and testbench
================================

// Module: pwm_ramp_ctrl
// PURPOSE
//  Duty-cycle sequencer for the single-channel PWM core. It drives pwm_en, pwm_period and
//  pwm_h_time, and steps the duty toward a requested target once per tick interval. In
//  breathe mode it sweeps the duty up and down continuously. A new duty is committed only
//  on the core's period-end strobe, so the PWM never emits a truncated or glitched pulse.
// PARAMETERS
//  W         16       width of period/duty/step values
//  PERIOD    10       PWM period in clk cycles; drives pwm_period (10 MHz/10 = 1 MHz)
//  TICK_DIV  5000000  clk cycles between duty steps (0.5 s at 10 MHz); must be >= 1
// PORTS
//  clk             in   1  system clock; all state on posedge
//  reset           in   1  asynchronous, active-high reset
//  start           in   1  one-cycle pulse; begin a ramp (ignored unless IDLE)
//  stop            in   1  one-cycle pulse; abort from any state
//  mode            in   1  0 = ramp once to target; 1 = breathe 0..PERIOD forever
//  target          in   W  duty goal for mode 0, sampled on accepted start
//  step            in   W  duty increment per tick, sampled on accepted start
//  pwm_period_end  in   1  one-cycle strobe from the PWM core when its counter wraps
//  pwm_en          out  1  enable to the PWM core
//  pwm_period      out  W  constant PERIOD
//  pwm_h_time      out  W  committed high time (duty) in clk cycles
//  pwm_update      out  1  one-cycle pulse in the cycle after pwm_h_time changes
//  busy            out  1  high in RAMP/COMMIT/DONE
//  done            out  1  one-cycle pulse when mode 0 reaches target
// BEHAVIOUR
//  Reset values: pwm_en=0, pwm_h_time=0, pwm_update=0, busy=0, done=0, state=IDLE,
//    timer=0, dir=up. pwm_period=PERIOD at all times.
//  Reset asserted mid-operation returns immediately to these values; any pending duty is lost.
//  States:
//   IDLE:   on start (and no stop in the same cycle):
//           - latch tgt=min(target,PERIOD), stp=(step==0)?1:step, mode.
//           - dir=up if tgt>=pwm_h_time, else down (mode 1: dir=up).
//           - pwm_en<=1, timer<=0, go RAMP.
//           - mode 0 with tgt==pwm_h_time: go DONE directly.
//   RAMP:   timer counts up by 1 each cycle. When timer==TICK_DIV-1: timer<=0, compute
//           pend, go COMMIT.
//   COMMIT: wait for pwm_period_end. On the strobe cycle:
//           - pwm_h_time<=pend; pwm_update asserts for the following cycle.
//           - mode 0: pend==tgt -> DONE, else RAMP.
//           - mode 1: pend==PERIOD -> dir=down; pend==0 -> dir=up; go RAMP.
//           - timer stays 0 while in COMMIT.
//   DONE:   done=1 for exactly one cycle, then IDLE. pwm_en stays 1 and the duty holds.
//  pend arithmetic is computed in W+1 bits so it never wraps:
//   - up:   min(h+stp, limit), limit=tgt (mode 0) or PERIOD (mode 1).
//   - down: max(h-stp, floor), floor=tgt (mode 0) or 0 (mode 1).
//  stop in any state: next state IDLE, pwm_en<=0, pend discarded, pwm_h_time unchanged.
//    stop wins over start and over pwm_period_end in the same cycle.
//  start while busy: ignored; latched tgt/stp/mode do not change.
//  A pwm_period_end that arrives outside COMMIT has no effect.
//  Latency:
//   - accepted start -> first commit: >= TICK_DIV cycles plus wait for pwm_period_end.
//   - commit -> pwm_update: 1 cycle.
// TESTING (PERIOD=10, TICK_DIV=4, pwm_period_end every 10th cycle)
//  1 reset held, then released -> all outputs at reset values; pwm_period==10; no pwm_update.
//  2 mode0, h=0, target=3, step=1 -> h_time 1,2,3, each change on a period_end strobe;
//    done pulses once after 3; busy falls; pwm_en stays 1.
//  3 mode0, h=3, target=8, step=4 -> h_time 7 then 8 (saturate); target=2 from 8, step=4 -> 4, 2.
//  4 mode1, step=3 -> h_time 3,6,9,10,7,4,1,0,3 (reflect at 10 and 0); done never pulses.
//  5 stop during COMMIT while h=6 -> next cycle IDLE, pwm_en=0, h_time stays 6, no pwm_update.
//  6 target=20 -> clamps, ramp ends at 10; start+stop in the same cycle -> stays IDLE, pwm_en=0.

Source files
------------

// File: rtl/pwm_ramp_ctrl.sv
// pwm_ramp_ctrl
//   Duty-cycle sequencer for a single-channel PWM core. It steps the committed
//   high time toward a target once per TICK_DIV cycles. In breathe mode it
//   sweeps the duty between 0 and PERIOD forever. A new duty is committed only
//   on the core's period-end strobe, so the core never emits a truncated pulse.
// Parameters
//   W         width of period/duty/step values
//   PERIOD    PWM period in clk cycles, driven on pwm_period
//   TICK_DIV  clk cycles between duty steps (>= 1)
// Ports
//   clk, reset      clock; asynchronous active-high reset
//   start, stop     one-cycle command pulses; stop aborts and wins over start
//   mode            0 = ramp once to target, 1 = breathe 0..PERIOD
//   target, step    duty goal and increment, sampled on an accepted start
//   pwm_period_end  wrap strobe from the PWM core
//   pwm_en          enable to the PWM core
//   pwm_period      constant PERIOD
//   pwm_h_time      committed high time
//   pwm_update      pulse in the cycle after pwm_h_time changes
//   busy            high in RAMP/COMMIT/DONE
//   done            one-cycle pulse when a mode-0 ramp reaches its target
module pwm_ramp_ctrl #(
   parameter int unsigned W        = 16,
   parameter int unsigned PERIOD   = 10,
   parameter int unsigned TICK_DIV = 5000000
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         start,
   input  logic         stop,
   input  logic         mode,
   input  logic [W-1:0] target,
   input  logic [W-1:0] step,
   input  logic         pwm_period_end,
   output logic         pwm_en,
   output logic [W-1:0] pwm_period,
   output logic [W-1:0] pwm_h_time,
   output logic         pwm_update,
   output logic         busy,
   output logic         done
);

   typedef enum logic [1:0] {S_IDLE, S_RAMP, S_COMMIT, S_DONE} state_t;

   localparam int unsigned    TW         = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam logic [TW-1:0]  TIMER_LAST = TW'(TICK_DIV - 1);
   localparam logic [W-1:0]   PERIOD_W   = W'(PERIOD);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   logic          dir_down_q, dir_down_d;
   logic [W-1:0]  tgt_q, tgt_d;
   logic [W-1:0]  stp_q, stp_d;
   logic          mode_q, mode_d;
   logic [W-1:0]  pend_q, pend_d;
   logic [W-1:0]  h_q, h_d;
   logic          pwm_en_q, pwm_en_d;
   logic          update_q, update_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;

   logic [W-1:0]  tgt_clamp;
   logic [W-1:0]  limit_w;
   logic [W-1:0]  floor_w;
   logic [W-1:0]  pend_calc;

   always_comb begin
      tgt_clamp = ({1'b0, target} > {1'b0, PERIOD_W}) ? PERIOD_W : target;
      limit_w   = mode_q ? PERIOD_W : tgt_q;
      floor_w   = mode_q ? '0 : tgt_q;
      pend_calc = h_q;
      // Overflow/underflow are tested in W+1 bits before any W-bit result is used.
      if (!dir_down_q) begin
         if (({1'b0, h_q} + {1'b0, stp_q}) > {1'b0, limit_w})
            pend_calc = limit_w;
         else
            pend_calc = h_q + stp_q;
      end else begin
         if ((h_q < stp_q) || ((h_q - stp_q) < floor_w))
            pend_calc = floor_w;
         else
            pend_calc = h_q - stp_q;
      end
   end

   always_comb begin
      state_d    = state_q;
      timer_d    = timer_q;
      dir_down_d = dir_down_q;
      tgt_d      = tgt_q;
      stp_d      = stp_q;
      mode_d     = mode_q;
      pend_d     = pend_q;
      h_d        = h_q;
      pwm_en_d   = pwm_en_q;
      update_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (start) begin
               tgt_d      = tgt_clamp;
               stp_d      = (step == '0) ? W'(1) : step;
               mode_d     = mode;
               dir_down_d = mode ? 1'b0 : (tgt_clamp < h_q);
               pwm_en_d   = 1'b1;
               timer_d    = '0;
               state_d    = (!mode && (tgt_clamp == h_q)) ? S_DONE : S_RAMP;
            end
         end
         S_RAMP: begin
            if (timer_q == TIMER_LAST) begin
               timer_d = '0;
               pend_d  = pend_calc;
               state_d = S_COMMIT;
            end else begin
               timer_d = timer_q + TW'(1);
            end
         end
         S_COMMIT: begin
            if (pwm_period_end) begin
               h_d      = pend_q;
               update_d = 1'b1;
               state_d  = S_RAMP;
               if (!mode_q) begin
                  if (pend_q == tgt_q)
                     state_d = S_DONE;
               end else if (pend_q == PERIOD_W) begin
                  dir_down_d = 1'b1;
               end else if (pend_q == '0) begin
                  dir_down_d = 1'b0;
               end
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // stop overrides start and the period-end commit in the same cycle
      if (stop) begin
         state_d  = S_IDLE;
         pwm_en_d = 1'b0;
         update_d = 1'b0;
         h_d      = h_q;
         timer_d  = '0;
         pend_d   = pend_q;
         tgt_d    = tgt_q;
         stp_d    = stp_q;
         mode_d   = mode_q;
      end

      busy_d = (state_d != S_IDLE);
      done_d = (state_d == S_DONE);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q    <= S_IDLE;
         timer_q    <= '0;
         dir_down_q <= 1'b0;
         tgt_q      <= '0;
         stp_q      <= '0;
         mode_q     <= 1'b0;
         pend_q     <= '0;
         h_q        <= '0;
         pwm_en_q   <= 1'b0;
         update_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         timer_q    <= timer_d;
         dir_down_q <= dir_down_d;
         tgt_q      <= tgt_d;
         stp_q      <= stp_d;
         mode_q     <= mode_d;
         pend_q     <= pend_d;
         h_q        <= h_d;
         pwm_en_q   <= pwm_en_d;
         update_q   <= update_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
      end
   end

   assign pwm_en     = pwm_en_q;
   assign pwm_period = PERIOD_W;
   assign pwm_h_time = h_q;
   assign pwm_update = update_q;
   assign busy       = busy_q;
   assign done       = done_q;

endmodule

// File: tb/tb_pwm_ramp_ctrl.sv
// tb_pwm_ramp_ctrl
//   Scoreboard bench for pwm_ramp_ctrl with PERIOD=10, TICK_DIV=4 and a
//   period-end strobe every 10th cycle. Stimulus pushes the expected sequence
//   of committed duties and done pulses; the monitor pops them as the DUT
//   presents pwm_update/done.
module tb_pwm_ramp_ctrl;
   localparam int W = 16;

   logic         clk;
   logic         reset;
   logic         start;
   logic         stop;
   logic         mode;
   logic [W-1:0] target;
   logic [W-1:0] step;
   logic         pwm_period_end;
   logic         pwm_en;
   logic [W-1:0] pwm_period;
   logic [W-1:0] pwm_h_time;
   logic         pwm_update;
   logic         busy;
   logic         done;

   int errors = 0;
   int checks = 0;
   int exp_h[$];
   int exp_done = 0;
   int done_seen = 0;
   int pe_cnt = 0;
   int mon_e;

   pwm_ramp_ctrl #(.W(16), .PERIOD(10), .TICK_DIV(4)) dut (
      .clk(clk), .reset(reset), .start(start), .stop(stop), .mode(mode),
      .target(target), .step(step), .pwm_period_end(pwm_period_end),
      .pwm_en(pwm_en), .pwm_period(pwm_period), .pwm_h_time(pwm_h_time),
      .pwm_update(pwm_update), .busy(busy), .done(done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) pe_cnt <= (pe_cnt == 9) ? 0 : pe_cnt + 1;
   assign pwm_period_end = (pe_cnt == 9);

   // monitor: pops expectations whenever the DUT presents an update or done
   always @(negedge clk) begin
      if (!reset) begin
         if (pwm_update) begin
            checks++;
            if (exp_h.size() == 0) begin
               errors++;
               $display("FAIL upd_unexpected: pwm_h_time=%0d, required no update", pwm_h_time);
            end else begin
               mon_e = exp_h.pop_front();
               if (int'(pwm_h_time) != mon_e) begin
                  errors++;
                  $display("FAIL upd_value: pwm_h_time=%0d, required %0d", pwm_h_time, mon_e);
               end
            end
         end
         if (done) begin
            done_seen++;
            checks++;
            if (exp_done == 0) begin
               errors++;
               $display("FAIL done_unexpected: done=1, required 0");
            end else begin
               exp_done--;
               if (exp_h.size() != 0) begin
                  errors++;
                  $display("FAIL done_early: %0d updates outstanding, required 0", exp_h.size());
               end
            end
         end
      end
   end

   task automatic chk(input string name, input int act, input int req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0d, required %0d", name, act, req);
      end
   endtask

   task automatic pulse_start(input logic m, input int t, input int s);
      @(posedge clk);
      #1;
      mode   = m;
      target = W'(t);
      step   = W'(s);
      start  = 1'b1;
      @(posedge clk);
      #1;
      start  = 1'b0;
   endtask

   task automatic wait_idle(input string name);
      int n = 0;
      @(negedge clk);
      while (busy && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (busy) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: busy=1, required 0 within 400 cycles", name);
      end
   endtask

   task automatic wait_q_empty(input string name);
      int n = 0;
      while (exp_h.size() != 0 && n < 1000) begin
         @(posedge clk);
         n++;
      end
      if (exp_h.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout: %0d updates outstanding, required 0", name, exp_h.size());
         exp_h.delete();
      end
   endtask

   task automatic stop_pulse();
      @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
   endtask

   initial begin
      int d0;
      reset = 1'b1; start = 1'b0; stop = 1'b0; mode = 1'b0;
      target = '0; step = '0;

      // reset values
      repeat (3) @(negedge clk);
      chk("rst_en", int'(pwm_en), 0);
      chk("rst_h", int'(pwm_h_time), 0);
      chk("rst_upd", int'(pwm_update), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_done", int'(done), 0);
      chk("rst_period", int'(pwm_period), 10);
      @(posedge clk);
      #1 reset = 1'b0;
      repeat (5) @(negedge clk);
      chk("post_rst_h", int'(pwm_h_time), 0);

      // ramp up by 1 from 0 to 3
      exp_h.push_back(1); exp_h.push_back(2); exp_h.push_back(3);
      exp_done++;
      pulse_start(1'b0, 3, 1);
      wait_idle("t2");
      chk("t2_done_cnt", exp_done, 0);
      chk("t2_en", int'(pwm_en), 1);
      chk("t2_h", int'(pwm_h_time), 3);

      // saturating up 3->8 then down 8->2; extra start while busy is ignored
      exp_h.push_back(7); exp_h.push_back(8);
      exp_done++;
      pulse_start(1'b0, 8, 4);
      wait_idle("t3a");
      chk("t3a_h", int'(pwm_h_time), 8);
      exp_h.push_back(4); exp_h.push_back(2);
      exp_done++;
      pulse_start(1'b0, 2, 4);
      repeat (3) @(posedge clk);
      #1 mode = 1'b1; target = W'(0); step = W'(7); start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
      wait_idle("t3b");
      chk("t3b_h", int'(pwm_h_time), 2);
      chk("t3_done_cnt", exp_done, 0);

      // reset mid-ramp returns everything to reset values at once
      pulse_start(1'b0, 10, 1);
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      #1;
      chk("mid_rst_en", int'(pwm_en), 0);
      chk("mid_rst_h", int'(pwm_h_time), 0);
      chk("mid_rst_busy", int'(busy), 0);
      @(posedge clk);
      #1 reset = 1'b0;

      // breathe, step 3, reflecting at 10 and 0
      d0 = done_seen;
      foreach (exp_h[i]) exp_h.delete(i);
      exp_h = '{3, 6, 9, 10, 7, 4, 1, 0, 3};
      pulse_start(1'b1, 0, 3);
      wait_q_empty("t4");
      stop_pulse();
      @(negedge clk);
      chk("t4_en", int'(pwm_en), 0);
      chk("t4_busy", int'(busy), 0);
      chk("t4_h", int'(pwm_h_time), 3);
      repeat (30) @(negedge clk);
      chk("t4_no_done", done_seen - d0, 0);

      // stop during COMMIT with h=6: pending 9 is discarded
      exp_h.push_back(6);
      pulse_start(1'b0, 10, 3);
      wait_q_empty("t5");
      repeat (5) @(posedge clk);
      #1 stop = 1'b1;
      @(posedge clk);
      #1 stop = 1'b0;
      @(negedge clk);
      chk("t5_en", int'(pwm_en), 0);
      chk("t5_busy", int'(busy), 0);
      chk("t5_h", int'(pwm_h_time), 6);
      repeat (30) @(negedge clk);
      chk("t5_h_hold", int'(pwm_h_time), 6);

      // target above PERIOD clamps to 10
      exp_h.push_back(9); exp_h.push_back(10);
      exp_done++;
      pulse_start(1'b0, 20, 3);
      wait_idle("t6");
      chk("t6_h", int'(pwm_h_time), 10);
      chk("t6_en", int'(pwm_en), 1);

      // start and stop together: stop wins
      @(posedge clk);
      #1 mode = 1'b0; target = W'(5); step = W'(1); start = 1'b1; stop = 1'b1;
      @(posedge clk);
      #1 start = 1'b0; stop = 1'b0;
      @(negedge clk);
      chk("t6_ss_en", int'(pwm_en), 0);
      chk("t6_ss_busy", int'(busy), 0);
      repeat (30) @(negedge clk);
      chk("t6_ss_h", int'(pwm_h_time), 10);

      // step of 0 behaves as 1, ramping down 10->8
      exp_h.push_back(9); exp_h.push_back(8);
      exp_done++;
      pulse_start(1'b0, 8, 0);
      wait_idle("t7");
      chk("t7_h", int'(pwm_h_time), 8);

      // target equal to current duty goes straight to DONE
      exp_done++;
      pulse_start(1'b0, 8, 2);
      wait_idle("t8");
      chk("t8_done_cnt", exp_done, 0);
      chk("t8_h", int'(pwm_h_time), 8);
      chk("t8_en", int'(pwm_en), 1);

      repeat (20) @(negedge clk);
      chk("final_queue", exp_h.size(), 0);
      chk("final_done_cnt", exp_done, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
